// File: rtl/qif_spike_synapse_pkg.sv
// Shared types and arithmetic helpers for the QIF spike synapse and its rate monitor.
package qif_pkg;

  localparam int QIF_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REFR = 1'b1
  } qif_state_e;

  typedef struct packed {
    logic                    clip;
    logic signed [QIF_W-1:0] val;
  } qif_sat_t;

  // Adds in 9 bits so the overflow is visible, then clips back to 8 bits.
  function automatic qif_sat_t sat_add9(input logic signed [QIF_W-1:0] a,
                                        input logic signed [QIF_W-1:0] b);
    logic signed [QIF_W:0] s;
    qif_sat_t              r;
    s = $signed({a[QIF_W-1], a}) + $signed({b[QIF_W-1], b});
    if (s > 9'sd127) begin
      r.clip = 1'b1;
      r.val  = 8'sd127;
    end else if (s < -9'sd128) begin
      r.clip = 1'b1;
      r.val  = -8'sd128;
    end else begin
      r.clip = 1'b0;
      r.val  = s[QIF_W-1:0];
    end
    return r;
  endfunction

  // Positive values are forced down by at least 1; negatives settle via -1 >>> k = -1.
  function automatic logic signed [QIF_W-1:0] decay_step(input logic signed [QIF_W-1:0] cur,
                                                         input int shift);
    logic signed [QIF_W-1:0] d;
    d = cur >>> shift;
    if (d == 8'sd0 && cur > 8'sd0) d = 8'sd1;
    return cur - d;
  endfunction

endpackage

// File: rtl/qif_spike_synapse_if.sv
// Signal bundle between the spike source/host (master) and the synapse (slave).
interface qif_spike_synapse_if;
  import qif_pkg::*;

  // spike_in is a level sampled every cycle; rate_valid is a one-cycle pulse with
  // no ready: the consumer must take rate_out in the cycle rate_valid is high.
  logic                    ena;
  logic                    spike_in;
  logic signed [QIF_W-1:0] weight_in;
  logic                    weight_load;
  logic signed [QIF_W-1:0] b_out;
  logic [QIF_W-1:0]        rate_out;
  logic                    rate_valid;
  logic                    sat_out;
  qif_state_e              state_dbg;

  modport master (
    output ena, spike_in, weight_in, weight_load,
    input  b_out, rate_out, rate_valid, sat_out, state_dbg
  );

  modport slave (
    input  ena, spike_in, weight_in, weight_load,
    output b_out, rate_out, rate_valid, sat_out, state_dbg
  );
endinterface

// File: rtl/qif_spike_synapse_rate_window.sv
// Fixed-length window counter reporting how many events landed in each completed window.
module qif_rate_window
  import qif_pkg::*;
#(
  parameter int WINDOW = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena_i,
  input  logic             event_i,
  output logic [QIF_W-1:0] rate_o,
  output logic             rate_valid_o
);
  localparam int CW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);

  logic [CW-1:0]    win_q, win_d;
  logic [QIF_W-1:0] cnt_q, cnt_d;
  logic [QIF_W-1:0] rate_q, rate_d;
  logic             valid_q, valid_d;
  logic [QIF_W-1:0] cnt_inc;

  // The event of the last window cycle still belongs to that window.
  assign cnt_inc = (event_i && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

  always_comb begin
    win_d   = win_q;
    cnt_d   = cnt_q;
    rate_d  = rate_q;
    valid_d = 1'b0;
    if (ena_i) begin
      if (win_q == WIN_LAST) begin
        win_d   = '0;
        cnt_d   = '0;
        rate_d  = cnt_inc;
        valid_d = 1'b1;
      end else begin
        win_d = win_q + CW'(1);
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q   <= '0;
      cnt_q   <= '0;
      rate_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      rate_q  <= rate_d;
      valid_q <= valid_d;
    end
  end

  assign rate_o       = rate_q;
  assign rate_valid_o = valid_q;
endmodule

// File: rtl/qif_spike_synapse.sv
// Spike-to-current synapse: weighted saturating accumulation, decay, refractory gate, rate monitor.
module qif_spike_synapse
  import qif_pkg::*;
#(
  parameter logic signed [7:0] WEIGHT       = 8'sd24,
  parameter int                DECAY_SHIFT  = 2,
  parameter int                DECAY_PERIOD = 4,
  parameter int                REFRACT      = 2,
  parameter int                WINDOW       = 64
) (
  input logic               clk,
  input logic               rst_n,
  qif_spike_synapse_if.slave bus
);
  localparam logic [7:0] PRE_LAST = 8'(DECAY_PERIOD - 1);
  localparam logic [3:0] REFR_LD  = 4'(REFRACT);

  logic                    en;
  logic                    spike_q;
  logic                    spike_ev;
  logic                    accept;
  logic                    tick;
  qif_state_e              state_q, state_d;
  logic [3:0]              refr_q, refr_d;
  logic [7:0]              pre_q, pre_d;
  logic signed [QIF_W-1:0] cur_q, cur_d, cur_dec;
  logic signed [QIF_W-1:0] weight_q, weight_d;
  logic                    sat_q, sat_d;
  qif_sat_t                sum;

  assign en       = bus.ena;
  assign spike_ev = bus.spike_in & ~spike_q;

  // The edge register runs even while disabled so re-enabling on a high level is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_q <= 1'b0;
    else        spike_q <= bus.spike_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      refr_q  <= '0;
    end else begin
      state_q <= state_d;
      refr_q  <= refr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    refr_d  = refr_q;
    if (en) begin
      case (state_q)
        IDLE: if (spike_ev && REFRACT != 0) begin
          state_d = REFR;
          refr_d  = REFR_LD;
        end
        REFR: begin
          refr_d = refr_q - 4'd1;
          if (refr_q == 4'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    accept = 1'b0;
    if (en && state_q == IDLE) accept = spike_ev;
  end

  assign tick  = en && (pre_q == PRE_LAST);
  assign pre_d = !en ? pre_q : (tick ? 8'd0 : pre_q + 8'd1);

  // Decay is applied before the weight is added when both happen on one edge.
  always_comb begin
    cur_dec  = tick ? decay_step(cur_q, DECAY_SHIFT) : cur_q;
    sum      = sat_add9(cur_dec, weight_q);
    cur_d    = cur_q;
    weight_d = weight_q;
    sat_d    = sat_q;
    if (en) begin
      cur_d = accept ? sum.val : cur_dec;
      sat_d = sat_q | (accept & sum.clip);
      if (bus.weight_load) weight_d = bus.weight_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      cur_q    <= '0;
      weight_q <= WEIGHT;
      sat_q    <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      cur_q    <= cur_d;
      weight_q <= weight_d;
      sat_q    <= sat_d;
    end
  end

  qif_rate_window #(.WINDOW(WINDOW)) u_rate (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena_i        (en),
    .event_i      (accept),
    .rate_o       (bus.rate_out),
    .rate_valid_o (bus.rate_valid)
  );

  assign bus.b_out     = cur_q;
  assign bus.sat_out   = sat_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_qif_spike_synapse.sv
// Two synapse configurations on one stimulus stream, compared against an arithmetic model.
module tb_qif_spike_synapse;
  import qif_pkg::*;

  typedef struct {
    int cur;
    int weight;
    int en_idx;
    int last_acc;
    int win_cnt;
    int rate;
    int rate_valid;
    int sat;
    bit spike_q;
  } model_t;

  typedef struct {
    int dp;
    int shift;
    int rf;
    int wn;
  } cfg_t;

  localparam cfg_t CFG_A = '{dp: 4,   shift: 2, rf: 2, wn: 64};
  localparam cfg_t CFG_B = '{dp: 256, shift: 3, rf: 0, wn: 16};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       spike = 1'b0;
  logic       wload = 1'b0;
  logic [7:0] w_in = 8'd0;

  int n_checks = 0;
  int n_errors = 0;
  model_t ma, mb;

  qif_spike_synapse_if bus_a ();
  qif_spike_synapse_if bus_b ();

  assign bus_a.ena = ena;
  assign bus_a.spike_in = spike;
  assign bus_a.weight_load = wload;
  assign bus_a.weight_in = w_in;
  assign bus_b.ena = ena;
  assign bus_b.spike_in = spike;
  assign bus_b.weight_load = wload;
  assign bus_b.weight_in = w_in;

  qif_spike_synapse dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  qif_spike_synapse #(
    .WEIGHT(8'sd24), .DECAY_SHIFT(3), .DECAY_PERIOD(256), .REFRACT(0), .WINDOW(16)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset(output model_t m);
    m.cur = 0; m.weight = 24; m.en_idx = 0; m.last_acc = -1000;
    m.win_cnt = 0; m.rate = 0; m.rate_valid = 0; m.sat = 0; m.spike_q = 1'b0;
  endfunction

  function automatic int floor_div_pow2(input int v, input int k);
    int p;
    p = 1 << k;
    return (v >= 0) ? v / p : -((-v + p - 1) / p);
  endfunction

  function automatic void model_step(inout model_t m, input cfg_t c,
                                     input bit sp, input bit en, input bit wl, input int wi);
    bit ev, acc;
    int cur, d, s;
    ev = sp && !m.spike_q;
    m.spike_q = sp;
    if (!en) begin
      m.rate_valid = 0;
      return;
    end
    acc = ev && (m.en_idx - m.last_acc > c.rf);
    if (acc) m.last_acc = m.en_idx;
    cur = m.cur;
    if (m.en_idx % c.dp == c.dp - 1) begin
      d = floor_div_pow2(cur, c.shift);
      if (d == 0 && cur > 0) d = 1;
      cur = cur - d;
    end
    if (acc) begin
      s = cur + m.weight;
      if (s > 127)  begin s = 127;  m.sat = 1; end
      if (s < -128) begin s = -128; m.sat = 1; end
      cur = s;
    end
    m.cur = cur;
    if (wl) m.weight = wi;
    if (acc && m.win_cnt < 255) m.win_cnt++;
    if (m.en_idx % c.wn == c.wn - 1) begin
      m.rate = m.win_cnt;
      m.win_cnt = 0;
      m.rate_valid = 1;
    end else begin
      m.rate_valid = 0;
    end
    m.en_idx++;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_val("a_b_out", int'($signed(bus_a.b_out)), ma.cur);
    check_val("a_rate_out", int'(bus_a.rate_out), ma.rate);
    check_val("a_rate_valid", int'(bus_a.rate_valid), ma.rate_valid);
    check_val("a_sat_out", int'(bus_a.sat_out), ma.sat);
    check_val("b_b_out", int'($signed(bus_b.b_out)), mb.cur);
    check_val("b_rate_out", int'(bus_b.rate_out), mb.rate);
    check_val("b_rate_valid", int'(bus_b.rate_valid), mb.rate_valid);
    check_val("b_sat_out", int'(bus_b.sat_out), mb.sat);
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_cycle();
    @(posedge clk);
    model_step(ma, CFG_A, spike, ena, wload, int'($signed(w_in)));
    model_step(mb, CFG_B, spike, ena, wload, int'($signed(w_in)));
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit sp, input bit en, input bit wl, input logic [7:0] wi, input int n);
    spike = sp; ena = en; wload = wl; w_in = wi;
    for (int i = 0; i < n; i++) begin
      run_cycle();
      wload = 1'b0;
    end
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset(ma);
    model_reset(mb);
    compare_all();
    check_val("rst_a_b_out", int'($signed(bus_a.b_out)), 0);
    check_val("rst_b_b_out", int'($signed(bus_b.b_out)), 0);
    spike = 1'b0; wload = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset(ma);
    model_reset(mb);
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // single spike at the tenth enabled edge
    drive(0, 1, 0, 8'd0, 9);
    drive(1, 1, 0, 8'd0, 1);
    check_val("a_first_spike", int'($signed(bus_a.b_out)), 24);
    check_val("b_first_spike", int'($signed(bus_b.b_out)), 24);
    drive(0, 1, 0, 8'd0, 70);
    check_val("a_decayed_zero", int'($signed(bus_a.b_out)), 0);

    // fast spike train hitting the refractory window
    for (int i = 0; i < 8; i++) drive(i[0] ? 1'b0 : 1'b1, 1, 0, 8'd0, 1);
    drive(0, 1, 0, 8'd0, 60);

    // large weight saturates
    drive(0, 1, 1, 8'd100, 1);
    drive(1, 1, 0, 8'd0, 1);
    drive(0, 1, 0, 8'd0, 9);
    drive(1, 1, 0, 8'd0, 1);
    check_val("a_sat_set", int'(bus_a.sat_out), 1);
    check_val("b_sat_set", int'(bus_b.sat_out), 1);
    drive(0, 1, 0, 8'd0, 80);

    // negative weight, weight load coinciding with a spike
    drive(1, 1, 1, 8'hD8, 1);
    drive(0, 1, 0, 8'd0, 9);
    drive(1, 1, 0, 8'd0, 1);
    drive(0, 1, 0, 8'd0, 9);
    drive(1, 1, 0, 8'd0, 1);
    drive(0, 1, 0, 8'd0, 90);
    check_val("a_neg_settled", int'($signed(bus_a.b_out)), 0);

    // ena low across a rising spike, then raised with spike still high
    drive(1, 0, 0, 8'd0, 3);
    drive(1, 1, 0, 8'd0, 3);
    drive(0, 1, 0, 8'd0, 4);

    // randomized traffic with occasional disable and weight reloads
    for (int i = 0; i < 2500; i++) begin
      drive(($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 90) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 4)  ? 1'b1 : 1'b0,
            8'($urandom_range(0, 255)), 1);
      if (i == 1200) async_reset();
    end

    // reset in the middle of a decay
    drive(1, 1, 1, 8'd90, 1);
    drive(0, 1, 0, 8'd0, 2);
    drive(1, 1, 0, 8'd0, 1);
    drive(0, 1, 0, 8'd0, 3);
    async_reset();
    drive(0, 1, 0, 8'd0, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/qif_spike_synapse.md
Name: qif_spike_synapse

Overview:
Receive end of the QIF neuron's spike interface. Converts a presynaptic spike train into a signed 8-bit synaptic current for a downstream neuron's B input:
- weighted, saturating accumulation on each accepted spike;
- exponential decay toward zero;
- refractory window after each accepted spike;
- windowed spike-rate measurement for observation.

Parameters:
WEIGHT, 8'sd24, reset value of the internal weight register (signed 8-bit)
DECAY_SHIFT, 2, decay step = current >>> DECAY_SHIFT (arithmetic); legal 1..7
DECAY_PERIOD, 4, clock cycles between decay steps; legal 1..256
REFRACT, 2, cycles after an accepted spike during which new spikes are ignored; legal 0..15
WINDOW, 64, rate-measurement window length in cycles; legal 2..65536

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  clock enable; low freezes all state except the spike edge register
spike_in  input  1  presynaptic spike (neuron spike output), level
weight_in  input  8  signed new weight value
weight_load  input  1  load weight_in into weight register
b_out  output  8  signed synaptic current, registered; drives downstream B
rate_out  output  8  accepted spikes in the last completed window, saturating at 255
rate_valid  output  1  one-cycle pulse when rate_out updates
sat_out  output  1  sticky flag: current accumulation clipped at least once

Behaviour:
- Reset (async, rst_n=0): b_out=0, rate_out=0, rate_valid=0, sat_out=0, weight=WEIGHT, state=IDLE, spike edge register=0, all counters=0.
- Edge detect: event = spike_in & ~spike_q. spike_q <= spike_in every cycle, including when ena=0, so ena rising never creates a spurious event.
- FSM:
  - IDLE: event -> accept, load refract counter with REFRACT, go REFR (if REFRACT=0, stay IDLE).
  - REFR: counter decrements each enabled cycle; events are dropped; at counter=1 -> IDLE.
  - Net effect: an accepted event at edge N blocks events at N+1..N+REFRACT. An event at N+REFRACT+1 is accepted.
- Decay tick: prescale counter 0..DECAY_PERIOD-1, wraps; tick on terminal count.
  - On tick: d = cur >>> DECAY_SHIFT; if d==0 and cur>0 then d=1; cur_dec = cur - d. Otherwise cur_dec = cur.
  - Negative values converge through -1 -> 0 because -1 >>> k = -1.
- Current update, same edge as the event (latency 1 clock from spike_in sampled high):
  - cur_next = sat(cur_dec + weight) if accepted, else cur_dec.
  - Compute in 9-bit signed; clip to [-128, 127]. sat_out sets on any clip.
  - Simultaneous tick and event: decay applies first, then add.
- Weight: weight_load registers weight_in at the edge. An event at that same edge uses the old weight.
- Rate window:
  - Cycle counter 0..WINDOW-1; accepted-event counter saturates at 255.
  - On the last window cycle: rate_out <= count including any event that cycle; rate_valid=1 for exactly that cycle; count clears to 0.
- ena=0: FSM, prescaler, window counter, current, weight load and rate_valid are all held. rate_valid is forced 0.
- Reset mid-operation returns everything to reset values immediately. No partial window is reported.

Decomposition:
- Package qif_pkg holds:
  - QIF_W=8;
  - state enum {IDLE, REFR};
  - function sat_add9 (9-bit signed to clipped 8-bit, plus clip flag);
  - function decay_step.
- Sub-module qif_rate_window contains the window counter, saturating event counter and rate_valid pulse. Reusable for the neuron's own output monitoring.

Test Plan:
- Defaults, single 1-cycle spike at edge 10 -> b_out=24 after edge 10. Decay ticks give 18,14,11,9,7,6,5,4,3,2,1,0, then b_out holds 0.
- REFRACT=2, spikes at edges 10,11,12,13 (each spike_in high one cycle, low between as applicable) -> only 10 and 13 accepted. b_out follows two weight additions; rate_out counts 2.
- DECAY_PERIOD=256, weight_in=100 loaded, spikes at edges 20 and 30 -> b_out=100 then 127; sat_out=1 and stays 1.
- weight_in=-40 loaded, spikes at edges 20 and 30 with DECAY_PERIOD=256 -> b_out=-40 then -80. Then with default decay the value reaches 0 via -1 -> 0.
- WINDOW=64, 5 accepted spikes in the first window -> rate_valid pulses at cycle 63 with rate_out=5. Next window with no spikes -> rate_out=0. A spike exactly at cycle 63 is counted in that window.
- ena held 0 across a spike_in pulse, then raised with spike_in still high -> no event, b_out unchanged. Assert rst_n low mid-decay -> b_out=0 immediately.
